// File: rtl/smart_counter.sv
// Loadable, enable-gated up-counter with clamped load, terminal-count and wrap pulse.
// Define SMART_COUNTER_SATURATE_EN to hold at MAX_VALUE instead of wrapping.
module smart_counter #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count_out,
    output logic             terminal_count,
    output logic             wrap
);

    // Loaded values above MAX_VALUE would leave the counter outside its modulus.
    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] value);
        clamp_to_max = (value > MAX_VALUE) ? MAX_VALUE : value;
    endfunction

    logic at_max;

    assign at_max         = (count_out == MAX_VALUE);
    assign terminal_count = at_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_out <= '0;
            wrap      <= 1'b0;
        end else if (load) begin
            count_out <= clamp_to_max(data_in);
            wrap      <= 1'b0;
        end else if (enable) begin
            if (at_max) begin
`ifdef SMART_COUNTER_SATURATE_EN
                count_out <= MAX_VALUE;
                wrap      <= 1'b0;
`else
                count_out <= '0;
                wrap      <= 1'b1;
`endif
            end else begin
                count_out <= count_out + 1'b1;
                wrap      <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_smart_counter.sv
// Directed, table-driven bench for smart_counter (default and MAX_VALUE=9 instances).
module tb_smart_counter;

`ifdef SMART_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       ld;
        logic       en;
        logic [7:0] din;
        logic [7:0] cnt;
        logic       tc;
        logic       wr;
    } vec_t;

    localparam int NVEC = 17;

    logic       clk = 1'b0;
    logic       reset, enable, load;
    logic [7:0] data_in;
    logic [7:0] count_out;
    logic       terminal_count, wrap;

    logic       rst9, en9, ld9;
    logic [7:0] din9;
    logic [7:0] cnt9;
    logic       tc9, wrap9;

    int total = 0;
    int bad   = 0;
    vec_t vecs[NVEC];

    always #10 clk = ~clk;

    smart_counter #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .data_in(data_in), .count_out(count_out),
        .terminal_count(terminal_count), .wrap(wrap)
    );

    smart_counter #(.WIDTH(8), .MAX_VALUE(8'd9)) dut9 (
        .clk(clk), .reset(rst9), .enable(en9), .load(ld9),
        .data_in(din9), .count_out(cnt9),
        .terminal_count(tc9), .wrap(wrap9)
    );

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d want=%0d", name, step, act, exp);
        end
    endtask

    task automatic step9(input logic r, input logic l, input logic e, input logic [7:0] d,
                         input int id, input logic [7:0] c, input logic t, input logic w);
        rst9 = r; ld9 = l; en9 = e; din9 = d;
        @(posedge clk);
        #1;
        chk("cnt9", id, 32'(cnt9), 32'(c));
        chk("tc9", id, 32'(tc9), 32'(t));
        chk("wrap9", id, 32'(wrap9), 32'(w));
    endtask

    initial begin
        // rst ld en din | cnt tc wr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd10,  8'd10,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'd0,   8'd11,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'd0,   8'd12,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd12,  1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'd50,  8'd50,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'd255, 8'd255, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'd0,   SAT ? 8'd255 : 8'd0, SAT, ~SAT};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'd0,   SAT ? 8'd255 : 8'd1, SAT, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'd28,  8'd28,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'd29,  1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'd30,  1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'd99,  8'd0,   1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'd1,   1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'd2,   1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd2,   1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'bx, 1'bx, 8'hxx,  8'd0,   1'b0, 1'b0};

        rst9 = 1'b1; ld9 = 1'b0; en9 = 1'b0; din9 = 8'd0;
        reset = 1'b0; load = 1'b0; enable = 1'b0; data_in = 8'd0;

        for (int i = 0; i < NVEC; i++) begin
            reset   = vecs[i].rst;
            load    = vecs[i].ld;
            enable  = vecs[i].en;
            data_in = vecs[i].din;
            @(posedge clk);
            #1;
            chk("count", i, 32'(count_out), 32'(vecs[i].cnt));
            chk("tc", i, 32'(terminal_count), 32'(vecs[i].tc));
            chk("wrap", i, 32'(wrap), 32'(vecs[i].wr));
        end

        // Reset leaves dut9 at 0; load clamps 200 down to 9 and then the next increment rolls over.
        step9(1'b1, 1'b0, 1'b0, 8'd0,   100, 8'd0, 1'b0, 1'b0);
        step9(1'b0, 1'b1, 1'b0, 8'd200, 101, 8'd9, 1'b1, 1'b0);
        step9(1'b0, 1'b0, 1'b1, 8'd0,   102, SAT ? 8'd9 : 8'd0, SAT, ~SAT);
        step9(1'b0, 1'b0, 1'b1, 8'd0,   103, SAT ? 8'd9 : 8'd1, SAT, 1'b0);
        step9(1'b0, 1'b1, 1'b0, 8'd7,   104, 8'd7, 1'b0, 1'b0);
        step9(1'b0, 1'b0, 1'b1, 8'd0,   105, 8'd8, 1'b0, 1'b0);
        step9(1'b0, 1'b0, 1'b1, 8'd0,   106, 8'd9, 1'b1, 1'b0);
        step9(1'b0, 1'b0, 1'b0, 8'd0,   107, 8'd9, 1'b1, 1'b0);
        step9(1'b0, 1'b1, 1'b0, 8'd9,   108, 8'd9, 1'b1, 1'b0);
        step9(1'b0, 1'b0, 1'b1, 8'd0,   109, SAT ? 8'd9 : 8'd0, SAT, ~SAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
